bcd_conv_scheduler: RTL and testbench
=====================================

Name: bcd_conv_scheduler

Overview:
- Shares one serial binary-to-BCD converter instance among NUM_REQ requesters.
- Each requester hands over a binary value with a valid/ready handshake. The block buffers one value per requester and grants the converter round-robin.
- It pulses the converter start and waits for the converter's data-valid. It then returns the BCD result with a one-cycle done strobe to the owning requester.
- A watchdog aborts a conversion that never completes and flags it as an error.
- The block sits between display/measurement producers and the converter.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- INPUT_WIDTH, 16, binary width; must match the converter.
- DECIMAL_DIGITS, 4, BCD digits; must match the converter.
- TIMEOUT, 1023, maximum cycles waited for converter data-valid (must be ≥ 2).

Ports:
- i_Clock  in  1  system clock.
- i_Rst_n  in  1  asynchronous active-low reset.
- i_Req  in  NUM_REQ  per-requester valid.
- i_Bin  in  NUM_REQ*INPUT_WIDTH  per-requester binary value; slice i is [i*INPUT_WIDTH +: INPUT_WIDTH].
- o_Ready  out  NUM_REQ  per-requester ready; equals not pending[i].
- o_Done  out  NUM_REQ  one-hot, one-cycle result strobe.
- o_Err  out  1  valid with o_Done; 1 = timeout, result invalid.
- o_BCD  out  DECIMAL_DIGITS*4  result; valid while any o_Done bit is high.
- o_Conv_Start  out  1  converter start pulse.
- o_Conv_Binary  out  INPUT_WIDTH  converter operand.
- i_Conv_BCD  in  DECIMAL_DIGITS*4  converter result.
- i_Conv_DV  in  1  converter data-valid pulse.

Behaviour:
- Reset (async assert, sync release) values:
  - state = S_IDLE; all pending = 0; o_Ready = all 1s; o_Done = 0; o_Err = 0; o_BCD = 0; o_Conv_Start = 0; o_Conv_Binary = 0; timer = 0.
  - last_grant = NUM_REQ-1, so requester 0 wins the first arbitration.
- Intake:
  - A transfer occurs when i_Req[i] & o_Ready[i] at a clock edge.
  - On transfer, hold[i] <= i_Bin slice and pending[i] <= 1.
  - i_Req while not ready is ignored; the requester must hold it.
  - Intake runs in every state, in parallel with the FSM.
- S_IDLE:
  - If any pending bit is set, grant = first set bit searching last_grant+1, +2, … modulo NUM_REQ.
  - Load o_Conv_Binary <= hold[grant], then go to S_START.
  - A request transferred on this same edge is not visible until the next cycle.
- S_START:
  - o_Conv_Start = 1 for exactly this cycle; timer <= 0; go to S_WAIT.
- S_WAIT:
  - If i_Conv_DV: o_BCD <= i_Conv_BCD, err <= 0, go to S_DONE.
  - Else if timer == TIMEOUT-1: err <= 1, o_BCD unchanged, go to S_DONE.
  - Else timer++.
  - DV takes priority if it arrives in the timeout cycle.
- S_DONE:
  - o_Done[grant] = 1 and o_Err = err for one cycle.
  - pending[grant] <= 0, so o_Ready[grant] rises the next cycle.
  - last_grant <= grant; go to S_IDLE.
- i_Conv_DV outside S_WAIT is ignored.
- o_Conv_Binary holds its value from S_IDLE exit until the next grant.
- Latency:
  - Request accepted at edge N (block idle) → o_Conv_Start high in cycle N+2.
  - DV sampled at edge M → o_Done high in cycle M+1.
  - Minimum back-to-back gap between starts is 3 cycles after DV.
- Reset mid-conversion aborts everything: pending requests are lost and no o_Done is issued.
  - The converter shares i_Rst_n-derived reset in the top level; otherwise the next start may be dropped and end in a timeout.
- After a timeout, arbitration continues normally.
- Fairness: no requester is served twice while another requester is pending.

Decomposition:
- Shared package: state encoding (S_IDLE, S_START, S_WAIT, S_DONE as 2-bit constants) and the timer width, computed as clog2(TIMEOUT+1).
- One sub-module: rr_pick. It is combinational, with inputs pending and last_grant and outputs grant index and any_pending. It is reusable by other shared-resource schedulers in the design.

Test Plan:
- Single request: requester 0, value 1234 (0x04D2), real converter → o_Done = 4'b0001, o_BCD = 16'h1234, o_Err = 0; o_Conv_Start exactly one cycle high.
- Simultaneous requests: requesters 0, 1, 2 with values 1, 22, 333 in the same cycle → done order 0, 1, 2 with o_BCD 16'h0001, 16'h0022, 16'h0333; o_Ready[i] low until the respective done.
- Fairness: requester 0 re-requests 9999 immediately after each done, while 1 and 3 are pending with 7 and 4095 → service order 0, 1, 3, 0; results 16'h9999, 16'h0007, 16'h4095, 16'h9999.
- Timeout: stub converter never asserts DV, TIMEOUT = 8 → o_Done with o_Err = 1 exactly 8 cycles after the start cycle ends; the next pending request is still served.
- Busy requester: i_Req[1] held high continuously with a changing i_Bin → only the value present at the accepting edge is converted; no second transfer until o_Ready[1] returns.
- Reset in S_WAIT: assert i_Rst_n low mid-conversion → all outputs return to reset values immediately; a late i_Conv_DV after release produces no o_Done.

Source files
------------

// File: rtl/bcd_conv_scheduler_pkg.sv
// Shared definitions for the BCD converter scheduler: FSM encoding and timer sizing.
package bcd_conv_scheduler_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Timer must be able to hold TIMEOUT-1 and the terminal compare value.
  function automatic int timer_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/bcd_conv_scheduler_if.sv
// Requester handshake and converter-side signals of the BCD converter scheduler.
interface bcd_conv_scheduler_if #(
  parameter int NUM_REQ        = 4,
  parameter int INPUT_WIDTH    = 16,
  parameter int DECIMAL_DIGITS = 4
);
  logic [NUM_REQ-1:0]             i_Req;
  logic [NUM_REQ*INPUT_WIDTH-1:0] i_Bin;
  logic [NUM_REQ-1:0]             o_Ready;
  logic [NUM_REQ-1:0]             o_Done;
  logic                           o_Err;
  logic [DECIMAL_DIGITS*4-1:0]    o_BCD;
  logic                           o_Conv_Start;
  logic [INPUT_WIDTH-1:0]         o_Conv_Binary;
  logic [DECIMAL_DIGITS*4-1:0]    i_Conv_BCD;
  logic                           i_Conv_DV;

  modport slave (
    input  i_Req, i_Bin, i_Conv_BCD, i_Conv_DV,
    output o_Ready, o_Done, o_Err, o_BCD, o_Conv_Start, o_Conv_Binary
  );

  modport master (
    output i_Req, i_Bin, i_Conv_BCD, i_Conv_DV,
    input  o_Ready, o_Done, o_Err, o_BCD, o_Conv_Start, o_Conv_Binary
  );
endinterface

// File: rtl/bcd_conv_scheduler_rr_pick.sv
// Combinational round-robin picker: first pending index after last_grant_i, wrapping.
module rr_pick #(
  parameter  int N  = 4,
  localparam int GW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  pending_i,
  input  logic [GW-1:0] last_grant_i,
  output logic [GW-1:0] grant_o,
  output logic          any_pending_o
);

  int          cand_s;
  logic [GW-1:0] idx_s;

  // Scan from the farthest candidate inward so the nearest pending index wins.
  always_comb begin
    grant_o = last_grant_i;
    cand_s  = 0;
    idx_s   = '0;
    for (int k = N; k >= 1; k--) begin
      cand_s  = (int'(last_grant_i) + k) % N;
      idx_s   = cand_s[GW-1:0];
      grant_o = pending_i[idx_s] ? idx_s : grant_o;
    end
  end

  assign any_pending_o = |pending_i;

endmodule

// File: rtl/bcd_conv_scheduler.sv
// Shares one serial binary-to-BCD converter among NUM_REQ requesters with
// round-robin arbitration, one-deep per-requester buffering and a timeout watchdog.
module bcd_conv_scheduler
  import bcd_conv_scheduler_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int INPUT_WIDTH    = 16,
  parameter int DECIMAL_DIGITS = 4,
  parameter int TIMEOUT        = 1023
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_n,
  bcd_conv_scheduler_if.slave  bus
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = timer_width(TIMEOUT);
  localparam int BW = DECIMAL_DIGITS * 4;

  state_e                 state_q, state_d;
  logic [NUM_REQ-1:0]     pending_q;
  logic [INPUT_WIDTH-1:0] hold_q [NUM_REQ];
  logic [GW-1:0]          grant_q, grant_d;
  logic [GW-1:0]          last_grant_q, last_grant_d;
  logic [GW-1:0]          pick_s;
  logic                   any_pending_s;
  logic [TW-1:0]          timer_q, timer_d;
  logic                   err_q, err_d;
  logic [BW-1:0]          bcd_q, bcd_d;
  logic [INPUT_WIDTH-1:0] conv_bin_q, conv_bin_d;
  logic                   release_s;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .pending_i     (pending_q),
    .last_grant_i  (last_grant_q),
    .grant_o       (pick_s),
    .any_pending_o (any_pending_s)
  );

  assign release_s = (state_q == S_DONE);

  // Intake runs independently of the FSM; the granted slot frees in S_DONE.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      pending_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.i_Req[i] && !pending_q[i]) begin
          pending_q[i] <= 1'b1;
          hold_q[i]    <= bus.i_Bin[i*INPUT_WIDTH +: INPUT_WIDTH];
        end else if (release_s && (grant_q == GW'(i))) begin
          pending_q[i] <= 1'b0;
        end
      end
    end
  end

  // FSM state and datapath registers.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_REQ - 1);
      timer_q      <= '0;
      err_q        <= 1'b0;
      bcd_q        <= '0;
      conv_bin_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      timer_q      <= timer_d;
      err_q        <= err_d;
      bcd_q        <= bcd_d;
      conv_bin_q   <= conv_bin_d;
    end
  end

  // Next-state logic; DV wins over the timeout when both land in the same cycle.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    timer_d      = timer_q;
    err_d        = err_q;
    bcd_d        = bcd_q;
    conv_bin_d   = conv_bin_q;
    case (state_q)
      S_IDLE: begin
        if (any_pending_s) begin
          grant_d    = pick_s;
          conv_bin_d = hold_q[pick_s];
          state_d    = S_START;
        end else begin
          state_d    = S_IDLE;
        end
      end
      S_START: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.i_Conv_DV) begin
          bcd_d   = bus.i_Conv_BCD;
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DONE: begin
        last_grant_d = grant_q;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.o_Ready       = ~pending_q;
  assign bus.o_Done        = release_s ? (NUM_REQ'(1) << grant_q) : '0;
  assign bus.o_Err         = release_s & err_q;
  assign bus.o_BCD         = bcd_q;
  assign bus.o_Conv_Start  = (state_q == S_START);
  assign bus.o_Conv_Binary = conv_bin_q;

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Scoreboard bench for bcd_conv_scheduler with a behavioural serial converter model.
module tb_bcd_conv_scheduler;

  localparam int LAT = 4;

  typedef struct packed {
    logic [3:0]  done;
    logic [15:0] bcd;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [63:0] bin_r;
  logic [3:0]  force_hold;
  logic        conv_live;
  logic        conv_dv_r, man_dv;
  logic [15:0] conv_bcd_r, man_bcd;
  int          iss_id [4];
  int          acc_id [4];
  exp_t        exp_q [$];
  int          total, bad;
  int          neg_cyc, start_cnt, done_cnt, last_start, last_done;

  bcd_conv_scheduler_if #(.NUM_REQ(4), .INPUT_WIDTH(16), .DECIMAL_DIGITS(4)) bus ();

  bcd_conv_scheduler #(
    .NUM_REQ(4), .INPUT_WIDTH(16), .DECIMAL_DIGITS(4), .TIMEOUT(8)
  ) dut (
    .i_Clock (clk),
    .i_Rst_n (rst_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // A requester asserts i_Req while it has an issued value not yet accepted.
  always_comb begin
    bus.i_Req = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      bus.i_Req[i] = (iss_id[i] != acc_id[i]) | force_hold[i];
    end
  end
  assign bus.i_Bin      = bin_r;
  assign bus.i_Conv_DV  = conv_dv_r | man_dv;
  assign bus.i_Conv_BCD = man_dv ? man_bcd : conv_bcd_r;

  function automatic logic [15:0] to_bcd(input logic [15:0] v);
    int          n;
    logic [15:0] r;
    n = int'(v);
    r = 16'h0000;
    for (int d = 0; d < 4; d++) begin
      r[d*4 +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input int idx, input logic [15:0] bcd, input logic err);
    exp_t e;
    e.done = 4'(32'd1 << idx);
    e.bcd  = bcd;
    e.err  = err;
    exp_q.push_back(e);
  endtask

  task automatic issue(input int idx, input logic [15:0] v, input logic [15:0] bcd, input logic err);
    bin_r[idx*16 +: 16] = v;
    iss_id[idx]++;
    push_exp(idx, bcd, err);
  endtask

  task automatic wait_done(input int n, input int budget);
    int target;
    bit hit;
    target = done_cnt + n;
    hit = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk);
      if (done_cnt >= target) begin
        hit = 1'b1;
        break;
      end
    end
    #1;
    if (!hit) begin
      total++;
      bad++;
      $display("FAIL wait_done timeout actual=%0d required=%0d", done_cnt, target);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Handshake tracker: retires an issued value once its transfer edge has passed.
  initial begin
    logic [3:0] acc_mask;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int i = 0; i < 4; i++) acc_id[i] = iss_id[i];
        acc_mask = 4'b0000;
      end else begin
        acc_mask = bus.i_Req & bus.o_Ready;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (acc_mask[i] && (acc_id[i] != iss_id[i])) acc_id[i]++;
      end
    end
  end

  // Converter model: DV pulse LAT cycles after a sampled start.
  initial begin
    int          cnt;
    logic [15:0] op;
    cnt = 0;
    op = 16'h0000;
    conv_dv_r = 1'b0;
    conv_bcd_r = 16'h0000;
    forever begin
      @(negedge clk);
      conv_dv_r = 1'b0;
      if (!rst_n) begin
        cnt = 0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          conv_dv_r  = 1'b1;
          conv_bcd_r = to_bcd(op);
        end
      end else if (bus.o_Conv_Start && conv_live) begin
        op  = bus.o_Conv_Binary;
        cnt = LAT;
      end
    end
  end

  // Monitor: pops the scoreboard on every done strobe.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      neg_cyc++;
      if (rst_n) begin
        if (bus.o_Conv_Start) begin
          start_cnt++;
          last_start = neg_cyc;
        end
        if (bus.o_Done != 4'b0000) begin
          done_cnt++;
          last_done = neg_cyc;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done actual=%b required=none", bus.o_Done);
          end else begin
            e = exp_q.pop_front();
            chk("done_vec", 32'(bus.o_Done), 32'(e.done));
            chk("bcd", 32'(bus.o_BCD), 32'(e.bcd));
            chk("err", 32'(bus.o_Err), 32'(e.err));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int n0, s0, d0;
    total = 0; bad = 0;
    neg_cyc = 0; start_cnt = 0; done_cnt = 0; last_start = 0; last_done = 0;
    for (int i = 0; i < 4; i++) begin
      iss_id[i] = 0;
      acc_id[i] = 0;
    end
    bin_r = 64'h0; force_hold = 4'b0000; conv_live = 1'b1;
    man_dv = 1'b0; man_bcd = 16'h0000;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_ready", 32'(bus.o_Ready), 32'(4'hF));
    chk("rst_done", 32'(bus.o_Done), 32'(4'h0));
    chk("rst_err", 32'(bus.o_Err), 32'(1'b0));
    chk("rst_bcd", 32'(bus.o_BCD), 32'(16'h0000));
    chk("rst_start", 32'(bus.o_Conv_Start), 32'(1'b0));
    chk("rst_conv_bin", 32'(bus.o_Conv_Binary), 32'(16'h0000));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single request: latency and single-cycle start.
    do_reset();
    n0 = neg_cyc;
    s0 = start_cnt;
    issue(0, 16'd1234, 16'h1234, 1'b0);
    wait_done(1, 100);
    chk("start_latency", 32'(last_start - n0), 32'd3);
    chk("dv_to_done", 32'(last_done - last_start), 32'(LAT + 1));
    repeat (3) @(posedge clk);
    #1;
    chk("start_cycles", 32'(start_cnt - s0), 32'd1);

    // Simultaneous requests on 0, 1, 2.
    do_reset();
    issue(0, 16'd1, 16'h0001, 1'b0);
    issue(1, 16'd22, 16'h0022, 1'b0);
    issue(2, 16'd333, 16'h0333, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("sim_ready0", 32'(bus.o_Ready), 32'(4'b1000));
    wait_done(1, 100);
    chk("sim_ready1", 32'(bus.o_Ready), 32'(4'b1001));
    wait_done(1, 100);
    chk("sim_ready2", 32'(bus.o_Ready), 32'(4'b1011));
    wait_done(1, 100);
    chk("sim_ready3", 32'(bus.o_Ready), 32'(4'b1111));
    chk("sim_queue_empty", 32'(exp_q.size()), 32'd0);

    // Fairness: requester 0 re-requests right after its done.
    do_reset();
    issue(0, 16'd9999, 16'h9999, 1'b0);
    issue(1, 16'd7, 16'h0007, 1'b0);
    issue(3, 16'd4095, 16'h4095, 1'b0);
    wait_done(1, 100);
    issue(0, 16'd9999, 16'h9999, 1'b0);
    wait_done(3, 200);
    chk("fair_queue_empty", 32'(exp_q.size()), 32'd0);

    // Timeout with a dead converter; next request still served.
    do_reset();
    conv_live = 1'b0;
    issue(0, 16'd42, 16'h0000, 1'b1);
    issue(1, 16'd5, 16'h0005, 1'b0);
    wait_done(1, 100);
    chk("timeout_gap", 32'(last_done - last_start), 32'd9);
    conv_live = 1'b1;
    wait_done(1, 100);
    chk("timeout_queue_empty", 32'(exp_q.size()), 32'd0);

    // Busy requester: i_Req[1] held while i_Bin changes every cycle.
    do_reset();
    s0 = start_cnt;
    d0 = done_cnt;
    bin_r[16 +: 16] = 16'd55;
    force_hold[1] = 1'b1;
    push_exp(1, 16'h0055, 1'b0);
    @(posedge clk);
    #1;
    begin
      bit ready_leak;
      bit finished;
      ready_leak = 1'b0;
      finished = 1'b0;
      for (int c = 0; c < 60; c++) begin
        @(negedge clk);
        #1;
        if (done_cnt > d0) begin
          force_hold[1] = 1'b0;
          finished = 1'b1;
          break;
        end
        ready_leak = ready_leak | bus.o_Ready[1];
        bin_r[16 +: 16] = 16'(100 + c);
      end
      force_hold[1] = 1'b0;
      chk("busy_finished", 32'(finished), 32'd1);
      chk("busy_ready_low", 32'(ready_leak), 32'd0);
    end
    repeat (4) @(posedge clk);
    #1;
    chk("busy_one_start", 32'(start_cnt - s0), 32'd1);
    chk("busy_ready_back", 32'(bus.o_Ready), 32'(4'hF));

    // Reset in S_WAIT: everything aborts, a late DV is ignored.
    do_reset();
    conv_live = 1'b0;
    bin_r[32 +: 16] = 16'd123;
    iss_id[2]++;
    repeat (6) @(posedge clk);
    #1;
    chk("wait_operand", 32'(bus.o_Conv_Binary), 32'd123);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    d0 = done_cnt;
    chk("abort_ready", 32'(bus.o_Ready), 32'(4'hF));
    chk("abort_done", 32'(bus.o_Done), 32'(4'h0));
    chk("abort_err", 32'(bus.o_Err), 32'(1'b0));
    chk("abort_bcd", 32'(bus.o_BCD), 32'(16'h0000));
    chk("abort_start", 32'(bus.o_Conv_Start), 32'(1'b0));
    chk("abort_conv_bin", 32'(bus.o_Conv_Binary), 32'(16'h0000));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    s0 = start_cnt;
    repeat (2) @(posedge clk);
    #1;
    man_bcd = 16'h0999;
    man_dv = 1'b1;
    @(posedge clk);
    #1 man_dv = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("late_dv_no_done", 32'(done_cnt - d0), 32'd0);
    chk("late_dv_no_start", 32'(start_cnt - s0), 32'd0);
    chk("late_dv_ready", 32'(bus.o_Ready), 32'(4'hF));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
